// File: rtl/data_mem_responder.sv
// Wait-stated data memory for the rv32i load/store bus: byte-lane stores, address error flags.
// Define DMEM_SIGNATURE_EN to build the sticky Done/Pass end-of-test signature detector.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] SIG_ADDR    = 100,
  parameter logic [31:0] SIG_VALUE   = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        AdrError,
  output logic        Done,
  output logic        Pass
);
  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [31:0] adr_q, wdata_q;
  logic [3:0]  be_q;
  logic        write_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] nxt_adr;
  logic        nxt_wr;
  logic        resp_err;

  function automatic logic adr_bad(input logic [31:0] a);
    return (|a[1:0]) || (|a[31:IW+2]);
  endfunction

  // With zero wait states RESP follows accept directly, so the read must use the live bus.
  assign nxt_adr  = (state == S_IDLE) ? DataAdr  : adr_q;
  assign nxt_wr   = (state == S_IDLE) ? MemWrite : write_q;
  assign resp_err = adr_bad(adr_q);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (MemReq) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt <= 4'd1) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      ReadData <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && MemReq) begin
        adr_q   <= DataAdr;
        wdata_q <= WriteData;
        be_q    <= ByteEn;
        write_q <= MemWrite;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_n == S_RESP && state != S_RESP && !nxt_wr)
        ReadData <= adr_bad(nxt_adr) ? '0 : mem[nxt_adr[IW+1:2]];
    end
  end

  // No reset on the array; a commit needs the RESP edge to land without reset.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && write_q && !resp_err) begin
      for (int l = 0; l < 4; l++)
        if (be_q[l]) mem[adr_q[IW+1:2]][8*l +: 8] <= wdata_q[8*l +: 8];
    end
  end

  assign MemReady = (state == S_RESP);
  assign AdrError = (state == S_RESP) && resp_err;

`ifdef DMEM_SIGNATURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Done <= 1'b0;
      Pass <= 1'b0;
    end else if (state == S_RESP && write_q && !resp_err && !Done &&
                 adr_q == SIG_ADDR && be_q == 4'hF) begin
      Done <= 1'b1;
      Pass <= (wdata_q == SIG_VALUE);
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^{SIG_ADDR, SIG_VALUE};
  assign Done = 1'b0;
  assign Pass = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 0 and 3 wait states) against a word/byte-lane memory model.
module tb_data_mem_responder;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]       req, wr, rdy, aerr, done, pass;
  logic [N-1:0][31:0] adr, wd, rd;
  logic [N-1:0][3:0]  be;

  int checks = 0;
  int passed = 0;

  logic [31:0] mmem   [N][64];
  logic [3:0]  mknown [N][64];
  bit          sdone  [N];
  bit          spass  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(64), .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .SIG_ADDR(100), .SIG_VALUE(25)
    ) u_dut (
      .clk(clk), .reset(reset), .MemReq(req[g]), .MemWrite(wr[g]),
      .DataAdr(adr[g]), .WriteData(wd[g]), .ByteEn(be[g]),
      .ReadData(rd[g]), .MemReady(rdy[g]), .AdrError(aerr[g]),
      .Done(done[g]), .Pass(pass[g])
    );
  end

  function automatic int ws(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) begin sdone[i] = 0; spass[i] = 0; end
  endtask

  // Called just after a rising edge; holds the request until MemReady, then idles two cycles.
  task automatic access(input int i, input bit w, input logic [31:0] a, d, input logic [3:0] b,
                        output logic [31:0] r, output bit e, output int lat, output int np);
    req[i] = 1'b1; wr[i] = w; adr[i] = a; wd[i] = d; be[i] = b;
    lat = -1; np = 0; r = 'x; e = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy[i]) begin
        np++;
        if (lat < 0) begin lat = k; r = rd[i]; e = aerr[i]; end
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    req[i] = 1'b0;
    repeat (2) begin @(negedge clk); if (rdy[i]) np++; end
    @(posedge clk); #1;
  endtask

  task automatic txn(input int i, input bit w, input logic [31:0] a, d, input logic [3:0] b,
                     output logic [31:0] r);
    bit e, ee; int lat, np, wi; logic [31:0] er;
    ee = (a % 4 != 0) || (a >= 4 * 64);
    wi = int'((a / 4) % 64);
    access(i, w, a, d, b, r, e, lat, np);
    checks++;
    if (lat != 1 + ws(i)) $display("FAIL latency inst%0d adr=%h: got %0d want %0d", i, a, lat, 1 + ws(i));
    else passed++;
    checks++;
    if (np != 1) $display("FAIL pulse_count inst%0d adr=%h: got %0d want 1", i, a, np);
    else passed++;
    checks++;
    if (e !== ee) $display("FAIL adr_error inst%0d adr=%h: got %0b want %0b", i, a, e, ee);
    else passed++;
    if (!w && (ee || mknown[i][wi] == 4'hF)) begin
      er = ee ? 32'h0 : mmem[i][wi];
      checks++;
      if (r !== er) $display("FAIL read_data inst%0d adr=%h: got %h want %h", i, a, r, er);
      else passed++;
    end
    if (w && !ee)
      for (int l = 0; l < 4; l++)
        if (b[l]) begin mmem[i][wi][8*l +: 8] = d[8*l +: 8]; mknown[i][wi][l] = 1'b1; end
`ifdef DMEM_SIGNATURE_EN
    if (w && a == 100 && b == 4'hF && !ee && !sdone[i]) begin sdone[i] = 1; spass[i] = (d == 25); end
`endif
    checks++;
    if (done[i] !== sdone[i] || pass[i] !== spass[i])
      $display("FAIL done_pass inst%0d: got %0b/%0b want %0b/%0b", i, done[i], pass[i], sdone[i], spass[i]);
    else passed++;
  endtask

  task automatic test_reset();
    int hits;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== 32'h0 || rdy[i] !== 1'b0 || aerr[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0)
        $display("FAIL reset_values inst%0d: got rd=%h rdy=%b err=%b done=%b pass=%b want all 0",
                 i, rd[i], rdy[i], aerr[i], done[i], pass[i]);
      else passed++;
    end
    reset = 1'b1; req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h5; be[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0; req[0] = 1'b0;
    hits = 0;
    repeat (4) begin @(negedge clk); if (rdy[0]) hits++; end
    @(posedge clk); #1;
    checks++;
    if (hits != 0) $display("FAIL reset_beats_req: got %0d pulses want 0", hits);
    else passed++;
  endtask

  task automatic test_store_load();
    logic [31:0] r;
    txn(0, 1, 32'h20, 32'h12345678, 4'hF, r);
    txn(0, 0, 32'h20, 32'h0, 4'h0, r);
    checks++;
    if (r !== 32'h12345678) $display("FAIL store_load: got %h want 12345678", r);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    txn(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, r);
    txn(0, 1, 32'h40, 32'h000000AB, 4'b0001, r);
    txn(0, 1, 32'h40, 32'h12345678, 4'b0000, r);
    txn(0, 0, 32'h40, 32'h0, 4'h0, r);
    checks++;
    if (r !== 32'hFFFFFFAB) $display("FAIL byte_lanes: got %h want ffffffab", r);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] r;
    txn(0, 1, 32'h22, 32'hCAFEF00D, 4'hF, r);
    txn(0, 0, 32'h20, 32'h0, 4'h0, r);
    checks++;
    if (r !== 32'h12345678) $display("FAIL misaligned_dropped: got %h want 12345678", r);
    else passed++;
    txn(0, 0, 32'h100, 32'h0, 4'h0, r);
    checks++;
    if (r !== 32'h0) $display("FAIL out_of_range_load: got %h want 0", r);
    else passed++;
  endtask

  task automatic test_signature();
    logic [31:0] r;
    txn(0, 1, 32'd100, 32'd25, 4'hF, r);
    do_reset();
    txn(0, 1, 32'd100, 32'd7, 4'hF, r);
    txn(0, 1, 32'd100, 32'd25, 4'hF, r);
    txn(0, 0, 32'd100, 32'h0, 4'h0, r);
`ifdef DMEM_SIGNATURE_EN
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b0) $display("FAIL sig_sticky: got %b/%b want 1/0", done[0], pass[0]);
    else passed++;
`endif
  endtask

  task automatic test_latency();
    logic [31:0] r;
    for (int i = 1; i < N; i++) begin
      txn(i, 1, 32'h8, 32'hA5A55A5A, 4'hF, r);
      txn(i, 0, 32'h8, 32'h0, 4'h0, r);
      txn(i, 0, 32'h3, 32'h0, 4'h0, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int hits;
    txn(0, 1, 32'h30, 32'h11110000, 4'hF, r);
    req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h30; wd[0] = 32'hDEAD; be[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1; req[0] = 1'b0;
    hits = 0;
    @(negedge clk); if (rdy[0]) hits++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin sdone[i] = 0; spass[i] = 0; end
    repeat (4) begin @(negedge clk); if (rdy[0]) hits++; end
    checks++;
    if (hits != 0 || rd[0] !== 32'h0) $display("FAIL reset_mid_abort: got %0d pulses rd=%h want 0 pulses rd=0", hits, rd[0]);
    else passed++;
    @(posedge clk); #1;
    txn(0, 0, 32'h30, 32'h0, 4'h0, r);
    checks++;
    if (r === 32'hDEAD) $display("FAIL reset_mid_no_commit: got %h want 11110000", r);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    int sel;
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 19);
        a = 32'($urandom_range(0, 15)) * 4;
        if (sel == 0) a = a | 32'($urandom_range(1, 3));
        else if (sel == 1) a = 32'h100 + 32'($urandom_range(0, 1000)) * 4;
        txn(i, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), r);
      end
  endtask

  initial begin
    req = '0; wr = '0; adr = '0; wd = '0; be = '0;
    for (int i = 0; i < N; i++) begin
      sdone[i] = 0; spass[i] = 0;
      for (int w = 0; w < 64; w++) begin mmem[i][w] = '0; mknown[i][w] = '0; end
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_signature();
    test_latency();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
